// File: rtl/retire_unit.sv
// ---------------------------------------------------------------------------
// retire_unit
//   Consumer end of the ROB->retire interface. Acknowledges the ROB head,
//   returns the stale physical register (t_old) to the free list and writes
//   the architectural map table. Stores are written to the data memory port
//   before they are acknowledged, so memory is updated in program order.
//
// Ports
//   clock, reset              : clock, synchronous active-high reset
//   rob_retire_*              : ROB head entry (en, tags, areg, store fields)
//   retire_ack                : combinational pulse, ROB pops head on this edge
//   fl_free_en / fl_free_idx  : registered free-list push
//   amt_wr_en / amt_areg/preg : registered AMT write
//   mem_req/addr/data         : store request, held stable while mem_req=1
//   mem_gnt, mem_done         : memory accept / write-complete handshake
//   busy                      : unit is not idle
//
// Optional feature (macro RETIRE_STATS_EN)
//   stat_retired, stat_stores, stat_stall_cycles : 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module retire_unit #(
   parameter int PREG_W = 6,
   parameter int AREG_W = 5,
   parameter int XLEN   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rob_retire_en,
   input  logic [PREG_W-1:0] rob_retire_t_idx,
   input  logic              rob_retire_t_valid,
   input  logic [PREG_W-1:0] rob_retire_t_old_idx,
   input  logic              rob_retire_t_old_valid,
   input  logic [AREG_W-1:0] rob_retire_areg,
   input  logic              rob_retire_wr_mem,
   input  logic [XLEN-1:0]   rob_retire_wr_addr,
   input  logic [XLEN-1:0]   rob_retire_wr_val,
   output logic              retire_ack,
   output logic              fl_free_en,
   output logic [PREG_W-1:0] fl_free_idx,
   output logic              amt_wr_en,
   output logic [AREG_W-1:0] amt_areg,
   output logic [PREG_W-1:0] amt_preg,
   output logic              mem_req,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_data,
   input  logic              mem_gnt,
   input  logic              mem_done,
   output logic              busy
`ifdef RETIRE_STATS_EN
   ,
   output logic [31:0]       stat_retired,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, ST_REQ, ST_WAIT, ACK_HOLD} state_t;

   state_t            r_state;
   logic [PREG_W-1:0] r_t_idx;
   logic              r_t_valid;
   logic [PREG_W-1:0] r_t_old_idx;
   logic              r_t_old_valid;
   logic [AREG_W-1:0] r_areg;
   logic              r_fl_free_en;
   logic [PREG_W-1:0] r_fl_free_idx;
   logic              r_amt_wr_en;
   logic [AREG_W-1:0] r_amt_areg;
   logic [PREG_W-1:0] r_amt_preg;
   logic              r_mem_req;
   logic [XLEN-1:0]   r_mem_addr;
   logic [XLEN-1:0]   r_mem_data;

   logic w_alu_ack;
   logic w_st_ack;
   logic w_ack;

   // ALU heads are acknowledged the cycle they are seen; a store only once
   // its write has completed (including grant and done in the same cycle).
   assign w_alu_ack = (r_state == IDLE) && rob_retire_en && !rob_retire_wr_mem;
   assign w_st_ack  = ((r_state == ST_WAIT) && mem_done) ||
                      ((r_state == ST_REQ) && mem_gnt && mem_done);
   assign w_ack     = !reset && (w_alu_ack || w_st_ack);

   assign retire_ack  = w_ack;
   assign fl_free_en  = r_fl_free_en;
   assign fl_free_idx = r_fl_free_idx;
   assign amt_wr_en   = r_amt_wr_en;
   assign amt_areg    = r_amt_areg;
   assign amt_preg    = r_amt_preg;
   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign mem_data    = r_mem_data;
   assign busy        = (r_state != IDLE);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_t_idx       <= '0;
         r_t_valid     <= 1'b0;
         r_t_old_idx   <= '0;
         r_t_old_valid <= 1'b0;
         r_areg        <= '0;
         r_fl_free_en  <= 1'b0;
         r_fl_free_idx <= '0;
         r_amt_wr_en   <= 1'b0;
         r_amt_areg    <= '0;
         r_amt_preg    <= '0;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_data    <= '0;
      end else begin
         // Free-list and AMT strobes are single-cycle pulses.
         r_fl_free_en <= 1'b0;
         r_amt_wr_en  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rob_retire_en) begin
                  if (rob_retire_wr_mem) begin
                     r_t_idx       <= rob_retire_t_idx;
                     r_t_valid     <= rob_retire_t_valid;
                     r_t_old_idx   <= rob_retire_t_old_idx;
                     r_t_old_valid <= rob_retire_t_old_valid;
                     r_areg        <= rob_retire_areg;
                     r_mem_addr    <= rob_retire_wr_addr;
                     r_mem_data    <= rob_retire_wr_val;
                     r_mem_req     <= 1'b1;
                     r_state       <= ST_REQ;
                  end else begin
                     r_fl_free_en  <= rob_retire_t_old_valid;
                     r_fl_free_idx <= rob_retire_t_old_idx;
                     r_amt_wr_en   <= rob_retire_t_valid;
                     r_amt_areg    <= rob_retire_areg;
                     r_amt_preg    <= rob_retire_t_idx;
                     r_state       <= ACK_HOLD;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  if (mem_done) begin
                     r_fl_free_en  <= r_t_old_valid;
                     r_fl_free_idx <= r_t_old_idx;
                     r_amt_wr_en   <= r_t_valid;
                     r_amt_areg    <= r_areg;
                     r_amt_preg    <= r_t_idx;
                     r_state       <= ACK_HOLD;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (mem_done) begin
                  r_fl_free_en  <= r_t_old_valid;
                  r_fl_free_idx <= r_t_old_idx;
                  r_amt_wr_en   <= r_t_valid;
                  r_amt_areg    <= r_areg;
                  r_amt_preg    <= r_t_idx;
                  r_state       <= ACK_HOLD;
               end
            end
            // The ROB head only advances on the ack edge, so the entry seen
            // here is stale; skip one cycle before accepting again.
            ACK_HOLD: r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase
      end
   end

`ifdef RETIRE_STATS_EN
   logic [31:0] r_stat_retired;
   logic [31:0] r_stat_stores;
   logic [31:0] r_stat_stall;

   assign stat_retired      = r_stat_retired;
   assign stat_stores       = r_stat_stores;
   assign stat_stall_cycles = r_stat_stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_retired <= '0;
         r_stat_stores  <= '0;
         r_stat_stall   <= '0;
      end else begin
         if (w_ack)
            r_stat_retired <= r_stat_retired + 32'd1;
         if (w_st_ack)
            r_stat_stores <= r_stat_stores + 32'd1;
         if ((r_state == ST_REQ) || (r_state == ST_WAIT))
            r_stat_stall <= r_stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// ---------------------------------------------------------------------------
// tb_retire_unit
//   Directed stimulus for retire_unit with a transaction-level model that is
//   compared against the DUT every cycle, plus literal expectations at the
//   key points of each scenario.
// ---------------------------------------------------------------------------
module tb_retire_unit;

   localparam int PREG_W = 6;
   localparam int AREG_W = 5;
   localparam int XLEN   = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              rob_retire_en = 1'b0;
   logic [PREG_W-1:0] rob_retire_t_idx = '0;
   logic              rob_retire_t_valid = 1'b0;
   logic [PREG_W-1:0] rob_retire_t_old_idx = '0;
   logic              rob_retire_t_old_valid = 1'b0;
   logic [AREG_W-1:0] rob_retire_areg = '0;
   logic              rob_retire_wr_mem = 1'b0;
   logic [XLEN-1:0]   rob_retire_wr_addr = '0;
   logic [XLEN-1:0]   rob_retire_wr_val = '0;
   logic              retire_ack;
   logic              fl_free_en;
   logic [PREG_W-1:0] fl_free_idx;
   logic              amt_wr_en;
   logic [AREG_W-1:0] amt_areg;
   logic [PREG_W-1:0] amt_preg;
   logic              mem_req;
   logic [XLEN-1:0]   mem_addr;
   logic [XLEN-1:0]   mem_data;
   logic              mem_gnt = 1'b0;
   logic              mem_done = 1'b0;
   logic              busy;
`ifdef RETIRE_STATS_EN
   logic [31:0]       stat_retired;
   logic [31:0]       stat_stores;
   logic [31:0]       stat_stall_cycles;
`endif

   retire_unit #(.PREG_W(PREG_W), .AREG_W(AREG_W), .XLEN(XLEN)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .rob_retire_en          (rob_retire_en),
      .rob_retire_t_idx       (rob_retire_t_idx),
      .rob_retire_t_valid     (rob_retire_t_valid),
      .rob_retire_t_old_idx   (rob_retire_t_old_idx),
      .rob_retire_t_old_valid (rob_retire_t_old_valid),
      .rob_retire_areg        (rob_retire_areg),
      .rob_retire_wr_mem      (rob_retire_wr_mem),
      .rob_retire_wr_addr     (rob_retire_wr_addr),
      .rob_retire_wr_val      (rob_retire_wr_val),
      .retire_ack             (retire_ack),
      .fl_free_en             (fl_free_en),
      .fl_free_idx            (fl_free_idx),
      .amt_wr_en              (amt_wr_en),
      .amt_areg               (amt_areg),
      .amt_preg               (amt_preg),
      .mem_req                (mem_req),
      .mem_addr               (mem_addr),
      .mem_data               (mem_data),
      .mem_gnt                (mem_gnt),
      .mem_done               (mem_done),
      .busy                   (busy)
`ifdef RETIRE_STATS_EN
      ,
      .stat_retired           (stat_retired),
      .stat_stores            (stat_stores),
      .stat_stall_cycles      (stat_stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: one outstanding store record, a "hold" cycle after
   // every acknowledgement, and the registered results of the last ack.
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic [PREG_W-1:0] t_idx;
      logic              t_valid;
      logic [PREG_W-1:0] t_old_idx;
      logic              t_old_valid;
      logic [AREG_W-1:0] areg;
   } head_t;

   logic              m_hold = 1'b0;
   logic              m_pend = 1'b0;
   logic              m_gntd = 1'b0;
   head_t             m_rec  = '0;
   logic              e_fl_en = 1'b0;
   logic [PREG_W-1:0] e_fl_idx = '0;
   logic              e_amt_en = 1'b0;
   logic [AREG_W-1:0] e_areg = '0;
   logic [PREG_W-1:0] e_preg = '0;
   logic [XLEN-1:0]   e_addr = '0;
   logic [XLEN-1:0]   e_data = '0;
   logic [31:0]       m_retired = '0;
   logic [31:0]       m_stores  = '0;
   logic [31:0]       m_stall   = '0;

   always @(negedge clock) begin : cmp
      logic  x_ack;
      logic  was_pend;
      head_t cur;
      head_t src;
      cur = '{rob_retire_t_idx, rob_retire_t_valid, rob_retire_t_old_idx,
              rob_retire_t_old_valid, rob_retire_areg};
      x_ack = !reset && !m_hold &&
              ((!m_pend && rob_retire_en && !rob_retire_wr_mem) ||
               (m_pend && mem_done && (m_gntd || mem_gnt)));
      if (chk_on) begin
         check("retire_ack", retire_ack, x_ack);
         check("fl_free_en", fl_free_en, e_fl_en);
         if (e_fl_en) check("fl_free_idx", fl_free_idx, e_fl_idx);
         check("amt_wr_en", amt_wr_en, e_amt_en);
         if (e_amt_en) begin
            check("amt_areg", amt_areg, e_areg);
            check("amt_preg", amt_preg, e_preg);
         end
         check("mem_req", mem_req, m_pend && !m_gntd);
         check("mem_addr", mem_addr, e_addr);
         check("mem_data", mem_data, e_data);
         check("busy", busy, m_pend || m_hold);
`ifdef RETIRE_STATS_EN
         check("stat_retired", stat_retired, m_retired);
         check("stat_stores", stat_stores, m_stores);
         check("stat_stall_cycles", stat_stall_cycles, m_stall);
`endif
      end
      was_pend = m_pend;
      if (reset) begin
         m_hold = 0; m_pend = 0; m_gntd = 0; m_rec = '0;
         e_fl_en = 0; e_fl_idx = '0; e_amt_en = 0; e_areg = '0; e_preg = '0;
         e_addr = '0; e_data = '0;
         m_retired = '0; m_stores = '0; m_stall = '0;
      end else begin
         e_fl_en  = 0;
         e_amt_en = 0;
         if (x_ack) begin
            src      = m_pend ? m_rec : cur;
            e_fl_en  = src.t_old_valid;
            e_fl_idx = src.t_old_idx;
            e_amt_en = src.t_valid;
            e_areg   = src.areg;
            e_preg   = src.t_idx;
            m_pend   = 0;
            m_gntd   = 0;
            m_hold   = 1;
            m_retired = m_retired + 1;
            if (was_pend) m_stores = m_stores + 1;
         end else if (m_hold) begin
            m_hold = 0;
         end else if (m_pend) begin
            if (mem_gnt) m_gntd = 1;
         end else if (rob_retire_en && rob_retire_wr_mem) begin
            m_pend = 1;
            m_gntd = 0;
            m_rec  = cur;
            e_addr = rob_retire_wr_addr;
            e_data = rob_retire_wr_val;
         end
         if (was_pend) m_stall = m_stall + 1;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge,
   // literal checks sample on the falling edge.
   // ---------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
   endtask

   task automatic set_head(input logic en, input logic wr,
                           input logic [PREG_W-1:0] t_idx, input logic tv,
                           input logic [PREG_W-1:0] t_old, input logic tov,
                           input logic [AREG_W-1:0] areg,
                           input logic [XLEN-1:0] addr, input logic [XLEN-1:0] val);
      rob_retire_en          = en;
      rob_retire_wr_mem      = wr;
      rob_retire_t_idx       = t_idx;
      rob_retire_t_valid     = tv;
      rob_retire_t_old_idx   = t_old;
      rob_retire_t_old_valid = tov;
      rob_retire_areg        = areg;
      rob_retire_wr_addr     = addr;
      rob_retire_wr_val      = val;
   endtask

   int acks;
   int req_cycles;

   initial begin
      repeat (2) @(posedge clock);
      #1;
      reset  = 1'b0;
      chk_on = 1'b1;
      smp();
      check("reset_busy", busy, 1'b0);
      check("reset_mem_req", mem_req, 1'b0);
      check("reset_fl_idx", fl_free_idx, 0);
      check("reset_amt_preg", amt_preg, 0);
      check("reset_mem_addr", mem_addr, 0);

      // ALU head: zero-latency ack, pulses next cycle, then hold.
      tick(); set_head(1, 0, 12, 1, 5, 1, 3, 0, 0);
      smp();  check("alu_ack", retire_ack, 1'b1);
      tick(); rob_retire_en = 0;
      smp();
      check("alu_fl_en", fl_free_en, 1'b1);
      check("alu_fl_idx", fl_free_idx, 5);
      check("alu_amt_en", amt_wr_en, 1'b1);
      check("alu_amt_areg", amt_areg, 3);
      check("alu_amt_preg", amt_preg, 12);
      check("alu_hold_ack", retire_ack, 1'b0);
      check("alu_hold_busy", busy, 1'b1);

      // Store: grant after 3 cycles, done 2 cycles after grant.
      tick(); set_head(1, 1, 20, 1, 7, 1, 9, 32'h1000, 32'hDEADBEEF);
      smp();  check("st_accept_ack", retire_ack, 1'b0);
      req_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) begin
            rob_retire_wr_addr = 32'h5555;     // must be ignored
            rob_retire_wr_val  = 32'h0;
         end
         mem_gnt  = (i == 3);
         mem_done = (i == 1);                  // done without grant is ignored
         smp();
         if (mem_req) req_cycles++;
         check("st_req_addr", mem_addr, 32'h1000);
         check("st_req_data", mem_data, 32'hDEADBEEF);
         check("st_req_ack", retire_ack, 1'b0);
      end
      tick(); mem_gnt = 0; mem_done = 0;
      smp();
      if (mem_req) req_cycles++;
      check("st_req_cycles", req_cycles, 4);
      check("st_wait_ack", retire_ack, 1'b0);
      tick(); mem_done = 1;
      smp();  check("st_done_ack", retire_ack, 1'b1);
      tick(); mem_done = 0; set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
      smp();
      check("st_fl_idx", fl_free_idx, 7);
      check("st_amt_areg", amt_areg, 9);
      check("st_amt_preg", amt_preg, 20);
      check("st_fl_en", fl_free_en, 1'b1);

      // No destination: ack but no pulses for three cycles.
      tick(); set_head(1, 0, 0, 0, 0, 0, 4, 0, 0);
      smp();  check("nodst_ack", retire_ack, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(); rob_retire_en = 0;
         smp();
         check("nodst_fl_en", fl_free_en, 1'b0);
         check("nodst_amt_en", amt_wr_en, 1'b0);
      end

      // Continuous ALU heads: acks on alternating cycles.
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick(); set_head(1, 0, 6'(30 + i), 1, 6'(i), 1, 5'(i + 1), 0, 0);
         smp();
         if (retire_ack) acks++;
         check("b2b_ack_pattern", retire_ack, (i % 2) == 0);
      end
      check("b2b_ack_count", acks, 3);
      tick(); rob_retire_en = 0;
      smp();

      // Reset while a store waits for mem_done.
      tick(); set_head(1, 1, 50, 1, 51, 1, 11, 32'h3000, 32'h12345678);
      smp();
      tick(); mem_gnt = 1;
      smp();  check("rst_st_req", mem_req, 1'b1);
      tick(); mem_gnt = 0; reset = 1;
      smp();  check("rst_st_busy", busy, 1'b1);
      tick(); reset = 0; set_head(0, 0, 0, 0, 0, 0, 0, 0, 0);
      smp();
      check("rst_busy", busy, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_fl_en", fl_free_en, 1'b0);
      check("rst_amt_en", amt_wr_en, 1'b0);
      tick(); mem_done = 1;                    // stray done in IDLE ignored
      smp();  check("rst_stray_done_ack", retire_ack, 1'b0);
      tick(); mem_done = 0; set_head(1, 0, 40, 1, 41, 1, 7, 0, 0);
      smp();  check("post_rst_ack", retire_ack, 1'b1);
      tick(); rob_retire_en = 0;
      smp();
      check("post_rst_fl_idx", fl_free_idx, 41);
      check("post_rst_amt_preg", amt_preg, 40);

      // Grant and done in the same cycle complete directly.
      tick(); set_head(1, 1, 60, 1, 61, 1, 13, 32'h2000, 32'hCAFEF00D);
      smp();
      tick(); mem_gnt = 1; mem_done = 1;
      smp();  check("gd_ack", retire_ack, 1'b1);
      tick(); mem_gnt = 0; mem_done = 0; rob_retire_en = 0;
      smp();
      check("gd_fl_idx", fl_free_idx, 61);
      check("gd_mem_req", mem_req, 1'b0);

`ifdef RETIRE_STATS_EN
      tick(); reset = 1;
      smp();
      tick(); reset = 0;
      smp();  check("stat_reset", stat_retired, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); set_head(1, 0, 6'(10 + i), 1, 6'(20 + i), 1, 5'(i), 0, 0);
         smp();
         tick(); rob_retire_en = 0;
         smp();
      end
      // Store A: 2 cycles in ST_REQ, 1 in ST_WAIT.
      tick(); set_head(1, 1, 1, 1, 2, 1, 3, 32'h4000, 32'h1);
      smp();
      tick(); smp();
      tick(); mem_gnt = 1; smp();
      tick(); mem_gnt = 0; mem_done = 1; smp();
      tick(); mem_done = 0; rob_retire_en = 0; smp();
      // Store B: grant and done together, 1 cycle in ST_REQ.
      tick(); set_head(1, 1, 4, 1, 5, 1, 6, 32'h4004, 32'h2);
      smp();
      tick(); mem_gnt = 1; mem_done = 1; smp();
      tick(); mem_gnt = 0; mem_done = 0; rob_retire_en = 0; smp();
      check("stat_retired_total", stat_retired, 6);
      check("stat_stores_total", stat_stores, 2);
      check("stat_stall_total", stat_stall_cycles, 4);
`endif

      tick(); smp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
